tlc_monitor: RTL and testbench
==============================

# tlc_monitor

Conflict/health monitor on the receiving end of the traffic-light controller's signal outputs. Samples the one-hot phase lines s1..s4 and the countdown timers t1..t4 on every enabled tick. Checks phase legality, phase ordering, dwell limits and timer behaviour. On any violation it latches a fault code and drives a flash output, and holds both until an explicit clear.

## Interface
- MIN_DWELL, 4: minimum enabled ticks a phase must last before a change is legal
- MAX_DWELL, 40: maximum enabled ticks a phase may last (≤ 63)
- FLASH_DIV, 8: clk cycles per half-period of the flash output
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  tick qualifier, the same one that drives the controller; samples are taken only when high
- s1, s2, s3, s4  in  1 each  phase lines from the controller
- t1, t2, t3, t4  in  4 each  countdown timers from the controller
- clear  in  1  fault acknowledge; acted on only in FAULT
- fault  out  1  latched fault flag
- fault_code  out  3  0 none, 1 one-hot, 2 sequence, 3 short dwell, 4 long dwell, 5 timer
- flash  out  1  square wave while in FAULT, 0 otherwise
- cur_phase  out  2  last accepted phase (s1→0 … s4→3)
- dwell  out  6  enabled ticks spent in cur_phase
- cycles  out  8  completed rotations (phase 3→0 transitions), wraps 255→0

## Operation
- States: INIT, RUN, FAULT. Reset enters INIT.
- Reset values: fault 0, fault_code 0, flash 0, cur_phase 0, dwell 0, cycles 0, flash divider 0, stored timers 0.
- When enable=0, no checks run and nothing updates except the flash divider.
- INIT, enabled sample:
  - exactly one s line high → cur_phase = that phase, dwell = 1, t1..t4 stored, go to RUN.
  - otherwise → FAULT with code 1.
- RUN, enabled sample. Checks are evaluated in priority order and the first failure sets the code:
  1. Number of s lines high ≠ 1 → code 1.
  2. New phase ≠ cur_phase and ≠ (cur_phase+1) mod 4 → code 2.
  3. Phase advanced with dwell < MIN_DWELL → code 3.
  4. Phase unchanged with dwell == MAX_DWELL → code 4.
  5. Any timer breaks all three legal rules → code 5. For each i, with p the stored value and n the new value, a step is legal if:
     - n == p−1 with p ≠ 0, or
     - n == p (hold), or
     - p == 0 and n ∈ {5, 15}.
- RUN, no failure:
  - store t1..t4.
  - phase advanced: dwell = 1, cur_phase = new phase; cycles += 1 (mod 256) if old phase was 3 and new is 0.
  - phase unchanged: dwell += 1.
- FAULT:
  - fault=1 and fault_code held; cur_phase, dwell and cycles frozen; enabled samples ignored.
  - flash toggles every FLASH_DIV clk cycles, free-running and independent of enable.
  - clear=1 → INIT on the next edge; fault, fault_code, flash, divider and dwell go to 0; cycles is kept.
- clear outside FAULT has no effect.
- A violation sampled in the same cycle as clear while in RUN still faults.

## Timing
- All outputs are registered.
- A violation present at edge k is visible on fault/fault_code immediately after edge k (one-edge latency from input to output).
- First flash toggle occurs FLASH_DIV clk cycles after entering FAULT; the period is 2·FLASH_DIV cycles.
- A clear sampled at edge k returns the block to INIT after edge k. The first enabled sample at edge k+1 or later is treated as an INIT sample.
- Asserting reset low mid-operation forces the reset values immediately, without waiting for a clock edge, and the block resumes in INIT after reset is released.

## Test plan
- Legal stream: drive the controller's sequence (s1 with t=5,5,10,15 counting down, phases advancing 0→1→2→3→0) for 2 rotations → fault stays 0, cycles = 2, dwell restarts at 1 on every phase change.
- One-hot: in RUN, drive s1=s2=1 on one enabled tick → fault=1 and fault_code=1 after that edge. flash first rises 8 clk later and then toggles every 8 clk.
- Sequence and short dwell:
  - jump phase 0→2 → code 2.
  - separately, advance 0→1 at dwell=3 → code 3.
  - separately, advance at dwell=4 → no fault.
- Long dwell: hold s1 with legal timer holds for 40 enabled ticks → code 4 on tick 41 (sample where dwell == 40).
- Timer: t3 steps 7→5 → code 5. t3 steps 0→15 → no fault. t3 steps 0→9 → code 5.
- Control:
  - enable=0 for 20 cycles → dwell and cycles are unchanged.
  - clear in FAULT → INIT, and the next legal sample resumes RUN with cycles preserved.
  - reset low mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/tlc_monitor.sv
// tlc_monitor: conflict/health monitor for traffic-light controller outputs.
// Checks phase one-hotness, ordering, dwell limits and timer steps; latches faults until cleared.
`default_nettype none

module tlc_monitor #(
    parameter int MIN_DWELL = 4,
    parameter int MAX_DWELL = 40,
    parameter int FLASH_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       s1,
    input  logic       s2,
    input  logic       s3,
    input  logic       s4,
    input  logic [3:0] t1,
    input  logic [3:0] t2,
    input  logic [3:0] t3,
    input  logic [3:0] t4,
    input  logic       clear,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash,
    output logic [1:0] cur_phase,
    output logic [5:0] dwell,
    output logic [7:0] cycles
);

    localparam int DIV_W = $clog2(FLASH_DIV + 1);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [3:0][3:0]    t_prev;
    logic [3:0][3:0]    t_new;
    logic [3:0]         s_vec;
    logic [2:0]         s_count;
    logic               one_hot;
    logic [1:0]         new_phase;
    logic               advanced;
    logic               timer_bad;
    logic [2:0]         run_code;

    // A timer step is legal if it counts down, holds, or reloads from 0 to 5 or 15.
    function automatic logic step_legal(input logic [3:0] p, input logic [3:0] n);
        return ((p != 4'd0) && (n == p - 4'd1)) || (n == p) ||
               ((p == 4'd0) && ((n == 4'd5) || (n == 4'd15)));
    endfunction

    always_comb begin
        s_vec     = {s4, s3, s2, s1};
        t_new     = {t4, t3, t2, t1};
        s_count   = 3'(s1) + 3'(s2) + 3'(s3) + 3'(s4);
        one_hot   = (s_count == 3'd1);
        new_phase = 2'd0;
        case (s_vec)
            4'b0010: new_phase = 2'd1;
            4'b0100: new_phase = 2'd2;
            4'b1000: new_phase = 2'd3;
            default: new_phase = 2'd0;
        endcase
        advanced  = (new_phase != cur_phase);
        timer_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!step_legal(t_prev[i], t_new[i])) timer_bad = 1'b1;
        end
        run_code = 3'd0;
        if (!one_hot)                                          run_code = 3'd1;
        else if (advanced && (new_phase != cur_phase + 2'd1))  run_code = 3'd2;
        else if (advanced && (dwell < 6'(MIN_DWELL)))          run_code = 3'd3;
        else if (!advanced && (dwell == 6'(MAX_DWELL)))        run_code = 3'd4;
        else if (timer_bad)                                    run_code = 3'd5;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= INIT;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            flash      <= 1'b0;
            cur_phase  <= 2'd0;
            dwell      <= 6'd0;
            cycles     <= 8'd0;
            div_cnt    <= '0;
            t_prev     <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (enable) begin
                        if (one_hot) begin
                            cur_phase <= new_phase;
                            dwell     <= 6'd1;
                            t_prev    <= t_new;
                            state     <= RUN;
                        end else begin
                            fault      <= 1'b1;
                            fault_code <= 3'd1;
                            state      <= FAULT;
                        end
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (run_code != 3'd0) begin
                            fault      <= 1'b1;
                            fault_code <= run_code;
                            state      <= FAULT;
                        end else begin
                            t_prev <= t_new;
                            if (advanced) begin
                                dwell     <= 6'd1;
                                cur_phase <= new_phase;
                                if ((cur_phase == 2'd3) && (new_phase == 2'd0))
                                    cycles <= cycles + 8'd1;
                            end else begin
                                dwell <= dwell + 6'd1;
                            end
                        end
                    end
                end
                FAULT: begin
                    if (clear) begin
                        state      <= INIT;
                        fault      <= 1'b0;
                        fault_code <= 3'd0;
                        flash      <= 1'b0;
                        div_cnt    <= '0;
                        dwell      <= 6'd0;
                    end else if (div_cnt == DIV_W'(FLASH_DIV - 1)) begin
                        div_cnt <= '0;
                        flash   <= ~flash;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tlc_monitor.sv
// Directed self-checking bench for tlc_monitor.
`default_nettype none

module tb_tlc_monitor;

    logic       clk = 1'b0;
    logic       reset, enable, clear;
    logic       s1, s2, s3, s4;
    logic [3:0] t1, t2, t3, t4;
    logic       fault, flash;
    logic [2:0] fault_code;
    logic [1:0] cur_phase;
    logic [5:0] dwell;
    logic [7:0] cycles;

    int checks = 0;
    int errors = 0;
    logic [3:0] tv [4];

    tlc_monitor #(.MIN_DWELL(4), .MAX_DWELL(40), .FLASH_DIV(8)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .s1(s1), .s2(s2), .s3(s3), .s4(s4),
        .t1(t1), .t2(t2), .t3(t3), .t4(t4),
        .clear(clear), .fault(fault), .fault_code(fault_code), .flash(flash),
        .cur_phase(cur_phase), .dwell(dwell), .cycles(cycles)
    );

    always #5 clk = ~clk;

    // One enabled (or not) sample using the current tv timer values.
    task automatic drive(input logic [3:0] s, input logic en);
        {s4, s3, s2, s1} = s;
        t1 = tv[0]; t2 = tv[1]; t3 = tv[2]; t4 = tv[3];
        enable = en;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    // Reset, then one INIT sample in phase 0 storing the given timers.
    task automatic restart(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        reset = 1'b0; clear = 1'b0; enable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        tv[0] = a; tv[1] = b; tv[2] = c; tv[3] = d;
        drive(4'b0001, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; clear = 1'b0;
        {s4, s3, s2, s1} = 4'b0000; t1 = 0; t2 = 0; t3 = 0; t4 = 0;
        #2;
        checks++; if ({fault, fault_code, flash, cur_phase, dwell, cycles} !== 21'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", {fault, fault_code, flash, cur_phase, dwell, cycles}); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_legal_stream();
        int ph;
        restart(4'd5, 4'd5, 4'd10, 4'd15);
        checks++; if (cur_phase !== 2'd0 || dwell !== 6'd1) begin errors++; $display("FAIL stream_init got=%0d/%0d exp=0/1", cur_phase, dwell); end
        for (int k = 1; k <= 32; k++) begin
            ph = (k / 4) % 4;
            tv[ph] = (tv[ph] == 4'd0) ? 4'd15 : tv[ph] - 4'd1;
            drive(4'b0001 << ph, 1'b1);
            checks++; if (fault !== 1'b0) begin errors++; $display("FAIL stream_fault k=%0d got=%b exp=0", k, fault); end
            checks++; if (cur_phase !== 2'(ph) || dwell !== 6'((k % 4) + 1)) begin errors++; $display("FAIL stream_phase_dwell k=%0d got=%0d/%0d exp=%0d/%0d", k, cur_phase, dwell, ph, (k % 4) + 1); end
            checks++; if (cycles !== ((k >= 32) ? 8'd2 : (k >= 16) ? 8'd1 : 8'd0)) begin errors++; $display("FAIL stream_cycles k=%0d got=%0d", k, cycles); end
        end
    endtask

    task automatic test_enable_low();
        {s4, s3, s2, s1} = 4'b1111; t1 = 4'd9; t2 = 4'd3; t3 = 4'd1; t4 = 4'd7;
        enable = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (dwell !== 6'd1 || cycles !== 8'd2 || cur_phase !== 2'd0 || fault !== 1'b0) begin errors++; $display("FAIL enable_low got dwell=%0d cycles=%0d phase=%0d fault=%b exp 1/2/0/0", dwell, cycles, cur_phase, fault); end
    endtask

    task automatic test_onehot_flash_clear();
        logic exp_flash;
        drive(4'b0011, 1'b1);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd1 || flash !== 1'b0) begin errors++; $display("FAIL onehot got=%b/%0d/%b exp=1/1/0", fault, fault_code, flash); end
        {s4, s3, s2, s1} = 4'b0010;
        enable = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            exp_flash = (e >= 8);
            checks++; if (flash !== exp_flash) begin errors++; $display("FAIL flash e=%0d got=%b exp=%b", e, flash, exp_flash); end
        end
        enable = 1'b0;
        checks++; if (cur_phase !== 2'd0 || dwell !== 6'd1 || cycles !== 8'd2 || fault_code !== 3'd1) begin errors++; $display("FAIL fault_frozen got=%0d/%0d/%0d/%0d exp=0/1/2/1", cur_phase, dwell, cycles, fault_code); end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++; if (fault !== 1'b0 || fault_code !== 3'd0 || flash !== 1'b0 || dwell !== 6'd0 || cycles !== 8'd2) begin errors++; $display("FAIL clear got=%b/%0d/%b/%0d/%0d exp=0/0/0/0/2", fault, fault_code, flash, dwell, cycles); end
        tv[0] = 4'd3; tv[1] = 4'd0; tv[2] = 4'd8; tv[3] = 4'd1;
        drive(4'b0100, 1'b1);
        checks++; if (fault !== 1'b0 || cur_phase !== 2'd2 || dwell !== 6'd1 || cycles !== 8'd2) begin errors++; $display("FAIL resume got=%b/%0d/%0d/%0d exp=0/2/1/2", fault, cur_phase, dwell, cycles); end
    endtask

    task automatic test_reset_midrun();
        #2 reset = 1'b0;
        #1;
        checks++; if ({fault, fault_code, flash, cur_phase, dwell, cycles} !== 21'd0) begin errors++; $display("FAIL reset_midrun got=%h exp=0", {fault, fault_code, flash, cur_phase, dwell, cycles}); end
        @(posedge clk); #1;
        reset = 1'b1;
        drive(4'b0010, 1'b1);
        checks++; if (fault !== 1'b0 || cur_phase !== 2'd1 || dwell !== 6'd1) begin errors++; $display("FAIL reinit got=%b/%0d/%0d exp=0/1/1", fault, cur_phase, dwell); end
    endtask

    task automatic test_sequence_dwell();
        restart(4'd5, 4'd5, 4'd10, 4'd15);
        drive(4'b0100, 1'b1);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd2) begin errors++; $display("FAIL sequence got=%b/%0d exp=1/2", fault, fault_code); end
        restart(4'd5, 4'd5, 4'd10, 4'd15);
        repeat (2) drive(4'b0001, 1'b1);
        drive(4'b0010, 1'b1);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd3) begin errors++; $display("FAIL short_dwell got=%b/%0d exp=1/3", fault, fault_code); end
        restart(4'd5, 4'd5, 4'd10, 4'd15);
        repeat (3) drive(4'b0001, 1'b1);
        drive(4'b0010, 1'b1);
        checks++; if (fault !== 1'b0 || cur_phase !== 2'd1 || dwell !== 6'd1) begin errors++; $display("FAIL min_dwell_ok got=%b/%0d/%0d exp=0/1/1", fault, cur_phase, dwell); end
    endtask

    task automatic test_long_dwell();
        restart(4'd5, 4'd5, 4'd10, 4'd15);
        repeat (39) drive(4'b0001, 1'b1);
        checks++; if (fault !== 1'b0 || dwell !== 6'd40) begin errors++; $display("FAIL dwell_40 got=%b/%0d exp=0/40", fault, dwell); end
        drive(4'b0001, 1'b1);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd4) begin errors++; $display("FAIL long_dwell got=%b/%0d exp=1/4", fault, fault_code); end
    endtask

    task automatic test_timer();
        restart(4'd5, 4'd5, 4'd7, 4'd15);
        tv[2] = 4'd5;
        drive(4'b0001, 1'b1);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd5) begin errors++; $display("FAIL timer_skip got=%b/%0d exp=1/5", fault, fault_code); end
        restart(4'd5, 4'd5, 4'd0, 4'd15);
        tv[2] = 4'd15;
        drive(4'b0001, 1'b1);
        checks++; if (fault !== 1'b0 || dwell !== 6'd2) begin errors++; $display("FAIL timer_reload got=%b/%0d exp=0/2", fault, dwell); end
        restart(4'd5, 4'd5, 4'd0, 4'd15);
        tv[2] = 4'd9;
        drive(4'b0001, 1'b1);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd5) begin errors++; $display("FAIL timer_bad_reload got=%b/%0d exp=1/5", fault, fault_code); end
    endtask

    task automatic test_clear_in_run();
        restart(4'd5, 4'd5, 4'd10, 4'd15);
        clear = 1'b1;
        drive(4'b1001, 1'b1);
        clear = 1'b0;
        checks++; if (fault !== 1'b1 || fault_code !== 3'd1) begin errors++; $display("FAIL clear_in_run got=%b/%0d exp=1/1", fault, fault_code); end
    endtask

    initial begin
        test_reset();
        test_legal_stream();
        test_enable_low();
        test_onehot_flash_clear();
        test_reset_midrun();
        test_sequence_dwell();
        test_long_dwell();
        test_timer();
        test_clear_in_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
